// File: rtl/mintypmax_tick_timer.sv
// mintypmax_tick_timer: periodic/one-shot tick generator with MIN/TYP/MAX/programmed delay select
module mintypmax_tick_timer #(
    parameter int WIDTH   = 8,
    parameter int MIN_DLY = 3,
    parameter int TYP_DLY = 10,
    parameter int MAX_DLY = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] prog_dly,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] tick_limit,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] tick_count,
    output logic [WIDTH-1:0] remaining
);
    if (MIN_DLY < 1 || MIN_DLY >= 2**WIDTH || TYP_DLY < 1 || TYP_DLY >= 2**WIDTH ||
        MAX_DLY < 1 || MAX_DLY >= 2**WIDTH) begin : g_bad_param
        $error("mintypmax_tick_timer: delay parameters must be in [1, 2**WIDTH)");
    end
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] d_raw, d, cnt_inc, rem_n, cnt_n, lim_q, lim_n;
    logic os_q, os_n, tick_n, fire, finish;
    always_comb begin
        d_raw   = sel == 2'd0 ? WIDTH'(MIN_DLY) : sel == 2'd1 ? WIDTH'(TYP_DLY) :
                  sel == 2'd2 ? WIDTH'(MAX_DLY) : prog_dly;
        d       = d_raw == '0 ? WIDTH'(1) : d_raw;
        cnt_inc = tick_count + 1'b1;
        fire    = remaining == WIDTH'(1);
        finish  = os_q || (lim_q != '0 && cnt_inc == lim_q);
    end
    // stop has priority in every state, including over an expiry on the same edge
    always_comb begin
        state_n = state;
        rem_n   = remaining;
        cnt_n   = tick_count;
        os_n    = os_q;
        lim_n   = lim_q;
        tick_n  = 1'b0;
        if (stop) begin
            state_n = IDLE;
            rem_n   = '0;
        end else if (state != RUN) begin
            if (start) begin
                state_n = RUN;
                rem_n   = d;
                cnt_n   = '0;
                os_n    = one_shot;
                lim_n   = tick_limit;
            end
        end else if (fire) begin
            tick_n  = 1'b1;
            cnt_n   = cnt_inc;
            state_n = finish ? DONE : RUN;
            rem_n   = finish ? '0 : d;
        end else begin
            rem_n = remaining - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            tick_count <= '0;
            tick       <= 1'b0;
            os_q       <= 1'b0;
            lim_q      <= '0;
        end else begin
            state      <= state_n;
            remaining  <= rem_n;
            tick_count <= cnt_n;
            tick       <= tick_n;
            os_q       <= os_n;
            lim_q      <= lim_n;
        end
    end
    assign busy = state == RUN;
    assign done = state == DONE;
endmodule
